// File: rtl/frame_serializer.sv
// Framing serializer: collects NUM_CHANNELS upstream words and emits
// HEADER, data, optional modular checksum and FOOTER with full ready/valid flow control.
module frame_serializer #(
  parameter int unsigned       DATA_W       = 8,
  parameter int unsigned       NUM_CHANNELS = 16,
  parameter logic [DATA_W-1:0] HEADER       = DATA_W'(8'hAA),
  parameter logic [DATA_W-1:0] FOOTER       = DATA_W'(8'hFF),
  parameter bit                CHECKSUM_EN  = 1'b1,
  parameter int unsigned       CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [CNT_W-1:0]  frame_count,
  output logic              busy
);

  localparam int unsigned      IDX_W    = $clog2(NUM_CHANNELS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_CKSUM,
    S_FOOTER
  } state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_sum;

  logic w_load;
  logic w_accept;

  // The output register may only change when it is empty or being drained.
  assign w_load   = !m_valid || m_ready;
  assign s_ready  = (r_state == S_DATA) && w_load;
  assign w_accept = s_valid && s_ready;
  assign busy     = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_sum       <= '0;
      m_data      <= '0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      frame_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_load) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            // s_valid only triggers the frame; the word itself is taken in S_DATA.
            if (s_valid) r_state <= S_HDR;
          end
        end

        S_HDR: begin
          if (w_load) begin
            m_data  <= HEADER;
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_state <= S_DATA;
          end
        end

        S_DATA: begin
          if (w_accept) begin
            m_data  <= s_data;
            m_valid <= 1'b1;
            r_sum   <= r_sum + s_data;
            r_idx   <= r_idx + IDX_W'(1);
            if (r_idx == LAST_IDX) r_state <= CHECKSUM_EN ? S_CKSUM : S_FOOTER;
          end else if (w_load) begin
            m_valid <= 1'b0;
          end
        end

        S_CKSUM: begin
          if (w_load) begin
            m_data  <= r_sum;
            m_valid <= 1'b1;
            r_state <= S_FOOTER;
          end
        end

        S_FOOTER: begin
          if (w_load) begin
            m_data      <= FOOTER;
            m_valid     <= 1'b1;
            m_last      <= 1'b1;
            frame_count <= frame_count + CNT_W'(1);
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_serializer.sv
// Scoreboard bench for frame_serializer: a default instance and a narrow
// 12-bit / 4-channel / no-checksum instance.
module tb_frame_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  s1_data;
  logic        s1_valid, s1_ready;
  logic [7:0]  m1_data;
  logic        m1_valid, m1_ready, m1_last;
  logic [15:0] fc1;
  logic        busy1;

  logic [11:0] s2_data;
  logic        s2_valid, s2_ready;
  logic [11:0] m2_data;
  logic        m2_valid, m2_ready, m2_last;
  logic [15:0] fc2;
  logic        busy2;

  frame_serializer dut1 (
    .clk(clk), .rst(rst),
    .s_data(s1_data), .s_valid(s1_valid), .s_ready(s1_ready),
    .m_data(m1_data), .m_valid(m1_valid), .m_ready(m1_ready), .m_last(m1_last),
    .frame_count(fc1), .busy(busy1)
  );

  frame_serializer #(
    .DATA_W(12), .NUM_CHANNELS(4), .CHECKSUM_EN(1'b0), .CNT_W(16)
  ) dut2 (
    .clk(clk), .rst(rst),
    .s_data(s2_data), .s_valid(s2_valid), .s_ready(s2_ready),
    .m_data(m2_data), .m_valid(m2_valid), .m_ready(m2_ready), .m_last(m2_last),
    .frame_count(fc2), .busy(busy2)
  );

  int checks = 0;
  int errors = 0;

  // Expected beats, {last, data}.
  logic [8:0]  q1[$];
  logic [12:0] q2[$];
  logic [8:0]  e1;
  logic [12:0] e2;
  int beats1 = 0, bubbles1 = 0, sready_cnt1 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitors sample between edges; a handshake seen here completes at the next posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy1 && !m1_valid) bubbles1++;
      if (s1_ready) sready_cnt1++;
      if (m1_valid && m1_ready) begin
        checks++;
        beats1++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL dut1_beat unexpected got last=%b data=%h", m1_last, m1_data);
        end else begin
          e1 = q1.pop_front();
          if ({m1_last, m1_data} !== e1) begin
            errors++;
            $display("FAIL dut1_beat got last=%b data=%h expected last=%b data=%h",
                     m1_last, m1_data, e1[8], e1[7:0]);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && m2_valid && m2_ready) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL dut2_beat unexpected got last=%b data=%h", m2_last, m2_data);
      end else begin
        e2 = q2.pop_front();
        if ({m2_last, m2_data} !== e2) begin
          errors++;
          $display("FAIL dut2_beat got last=%b data=%h expected last=%b data=%h",
                   m2_last, m2_data, e2[12], e2[11:0]);
        end
      end
    end
  end

  task automatic push1(input logic last, input logic [7:0] d);
    q1.push_back({last, d});
  endtask

  // HEADER, 0x01..0x10, checksum 0x88 (sum 136), FOOTER.
  task automatic push_ramp_frame1();
    push1(1'b0, 8'hAA);
    for (int i = 1; i <= 16; i++) push1(1'b0, 8'(i));
    push1(1'b0, 8'h88);
    push1(1'b1, 8'hFF);
  endtask

  task automatic send1(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    s1_data  = d;
    s1_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (s1_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("send1_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send2(input logic [11:0] d);
    bit ok;
    ok = 1'b0;
    s2_data  = d;
    s2_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (s2_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("send2_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain1(input string nm);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if (q1.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) chk(nm, q1.size(), 32'd0);
  endtask

  task automatic drain2(input string nm);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if (q2.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) chk(nm, q2.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    s1_data = '0; s1_valid = 1'b0; m1_ready = 1'b1;
    s2_data = '0; s2_valid = 1'b0; m2_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_data", m1_data, 32'h0);
    chk("rst_m_valid", m1_valid, 32'h0);
    chk("rst_m_last", m1_last, 32'h0);
    chk("rst_frame_count", fc1, 32'h0);
    chk("rst_busy", busy1, 32'h0);
    chk("rst_dut2_m_valid", m2_valid, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Contiguous ramp frame
    push_ramp_frame1();
    bubbles1 = 0; sready_cnt1 = 0;
    for (int i = 1; i <= 16; i++) send1(8'(i));
    s1_valid = 1'b0;
    drain1("t1_drain");
    chk("t1_frame_count", fc1, 32'd1);
    chk("t1_s_ready_cycles", sready_cnt1, 32'd16);
    chk("t1_bubbles", bubbles1, 32'd1);

    // All-0xFF frame with a 3-cycle downstream stall; 16*0xFF mod 256 = 0xF0
    push1(1'b0, 8'hAA);
    for (int i = 0; i < 16; i++) push1(1'b0, 8'hFF);
    push1(1'b0, 8'hF0);
    push1(1'b1, 8'hFF);
    base = beats1;
    fork
      begin
        for (int i = 0; i < 16; i++) send1(8'hFF);
      end
      begin
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
          @(posedge clk); #1;
          if (beats1 == base + 6) begin ok = 1'b1; break; end
        end
        if (!ok) chk("t2_stall_wait", beats1 - base, 32'd6);
        m1_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("t2_stall_m_valid", m1_valid, 32'h1);
          chk("t2_stall_m_data", m1_data, 32'hFF);
          chk("t2_stall_s_ready", s1_ready, 32'h0);
          @(posedge clk); #1;
        end
        m1_ready = 1'b1;
      end
    join
    s1_valid = 1'b0;
    drain1("t2_drain");
    chk("t2_frame_count", fc1, 32'd2);

    // Two-cycle upstream gap after the 8th word
    push_ramp_frame1();
    bubbles1 = 0;
    for (int i = 1; i <= 16; i++) begin
      send1(8'(i));
      if (i == 8) begin
        s1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
      end
    end
    s1_valid = 1'b0;
    drain1("t3_drain");
    chk("t3_frame_count", fc1, 32'd3);
    chk("t3_bubbles", bubbles1, 32'd3);

    // Two back-to-back frames with s_valid held high
    push_ramp_frame1();
    push_ramp_frame1();
    bubbles1 = 0;
    for (int f = 0; f < 2; f++)
      for (int i = 1; i <= 16; i++) send1(8'(i));
    s1_valid = 1'b0;
    drain1("t4_drain");
    chk("t4_frame_count", fc1, 32'd5);
    chk("t4_bubbles", bubbles1, 32'd2);

    // Abort mid-frame by reset while the 5th word is held in the output
    push1(1'b0, 8'hAA);
    for (int i = 0; i < 4; i++) push1(1'b0, 8'(8'h50 + i));
    for (int i = 0; i < 5; i++) send1(8'(8'h50 + i));
    m1_ready = 1'b0;
    s1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t5_pre_m_valid", m1_valid, 32'h1);
    chk("t5_pre_m_data", m1_data, 32'h54);
    chk("t5_pre_frame_count", fc1, 32'd5);
    chk("t5_pre_pending", q1.size(), 32'd0);
    rst = 1'b1;
    #1;
    chk("t5_rst_m_valid", m1_valid, 32'h0);
    chk("t5_rst_m_last", m1_last, 32'h0);
    chk("t5_rst_busy", busy1, 32'h0);
    chk("t5_rst_frame_count", fc1, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m1_ready = 1'b1;
    @(posedge clk); #1;
    push_ramp_frame1();
    for (int i = 1; i <= 16; i++) send1(8'(i));
    s1_valid = 1'b0;
    drain1("t5_drain");
    chk("t5_frame_count", fc1, 32'd1);

    // Narrow instance: 12-bit words, 4 channels, no checksum
    q2.push_back({1'b0, 12'h0AA});
    q2.push_back({1'b0, 12'h123});
    q2.push_back({1'b0, 12'h456});
    q2.push_back({1'b0, 12'h789});
    q2.push_back({1'b0, 12'hABC});
    q2.push_back({1'b1, 12'h0FF});
    send2(12'h123);
    send2(12'h456);
    send2(12'h789);
    send2(12'hABC);
    s2_valid = 1'b0;
    drain2("t6_drain");
    chk("t6_frame_count", fc2, 32'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("end_q1_empty", q1.size(), 32'd0);
    chk("end_q2_empty", q2.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
